// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo constants: default widths and the reserved "value ready" tag.
package tomasulo_pkg;

    localparam int unsigned N_SRC_DEFAULT  = 4;
    localparam int unsigned TAG_W_DEFAULT  = 5;
    localparam int unsigned DATA_W_DEFAULT = 32;

    // Tag 0 marks an operand that is already available; it never names a producer.
    localparam int unsigned TAG_NONE = 0;

    // Width of an index into n sources, never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Functional-unit result offers in, common data bus broadcast out.
interface cdb_arbiter_if import tomasulo_pkg::*; #(
    parameter int unsigned N_SRC  = N_SRC_DEFAULT,
    parameter int unsigned TAG_W  = TAG_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) ();

    logic [N_SRC-1:0]        fu_valid;
    logic [N_SRC*TAG_W-1:0]  fu_tag;
    logic [N_SRC*DATA_W-1:0] fu_val;
    logic [N_SRC-1:0]        fu_ready;
    logic                    cdb_broadcast;
    logic [TAG_W-1:0]        cdb_tag;
    logic [DATA_W-1:0]       cdb_val;
    logic                    tag_err;

    // Functional-unit / consumer side.
    modport master (
        output fu_valid, fu_tag, fu_val,
        input  fu_ready, cdb_broadcast, cdb_tag, cdb_val, tag_err
    );

    // Arbiter side.
    modport slave (
        input  fu_valid, fu_tag, fu_val,
        output fu_ready, cdb_broadcast, cdb_tag, cdb_val, tag_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after the last granted index.
module rr_arbiter import tomasulo_pkg::*; #(
    parameter int unsigned N_SRC = N_SRC_DEFAULT,
    parameter int unsigned IDX_W = idx_width(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [IDX_W-1:0] last_granted_i,
    output logic [N_SRC-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    int unsigned      cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan every source once, starting just after the previous winner.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        cand          = 0;
        cand_idx      = '0;
        for (int unsigned off = 1; off <= N_SRC; off++) begin
            cand     = (32'(last_granted_i) + off) % N_SRC;
            cand_idx = IDX_W'(cand);
            if (!grant_valid_o && req_i[cand_idx]) begin
                grant_valid_o     = 1'b1;
                grant_o[cand_idx] = 1'b1;
                grant_idx_o       = cand_idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one hold slot per functional unit, one broadcast per cycle.
module cdb_arbiter import tomasulo_pkg::*; #(
    parameter int unsigned N_SRC  = N_SRC_DEFAULT,
    parameter int unsigned TAG_W  = TAG_W_DEFAULT,
    parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
    input logic          clk,
    input logic          rst,
    cdb_arbiter_if.slave bus
);

    localparam int unsigned      IDX_W    = idx_width(N_SRC);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_SRC - 1);

    logic [N_SRC-1:0]             hold_valid_q, hold_valid_d;
    logic [N_SRC-1:0][TAG_W-1:0]  hold_tag_q, hold_tag_d;
    logic [N_SRC-1:0][DATA_W-1:0] hold_val_q, hold_val_d;
    logic [IDX_W-1:0]             last_q, last_d;
    logic                         cdb_broadcast_q, cdb_broadcast_d;
    logic [TAG_W-1:0]             cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]            cdb_val_q, cdb_val_d;
    logic                         tag_err_q, tag_err_d;

    logic [N_SRC-1:0] grant;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_valid;
    logic [N_SRC-1:0] fu_ready;
    logic [N_SRC-1:0] xfer;

    rr_arbiter #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_rr (
        .req_i          (hold_valid_q),
        .last_granted_i (last_q),
        .grant_o        (grant),
        .grant_idx_o    (grant_idx),
        .grant_valid_o  (grant_valid)
    );

    // A slot accepts when empty or when it drains this cycle, so a busy unit sees no bubble.
    always_comb begin
        fu_ready = '0;
        if (!rst) begin
            fu_ready = ~hold_valid_q | grant;
        end
    end

    assign xfer         = bus.fu_valid & fu_ready;
    assign bus.fu_ready = fu_ready;

    // Hold slots: drain the granted entry, then load any accepted non-zero-tag offer.
    always_comb begin
        hold_valid_d = hold_valid_q & ~grant;
        hold_tag_d   = hold_tag_q;
        hold_val_d   = hold_val_q;
        tag_err_d    = tag_err_q;
        for (int i = 0; i < N_SRC; i++) begin
            if (xfer[i]) begin
                if (bus.fu_tag[i*TAG_W +: TAG_W] == TAG_W'(TAG_NONE)) begin
                    // Tag 0 is never a producer; drop the value and flag the offender.
                    tag_err_d = 1'b1;
                end else begin
                    hold_valid_d[i] = 1'b1;
                    hold_tag_d[i]   = bus.fu_tag[i*TAG_W +: TAG_W];
                    hold_val_d[i]   = bus.fu_val[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Broadcast stage and round-robin pointer.
    always_comb begin
        last_d          = last_q;
        cdb_broadcast_d = 1'b0;
        cdb_tag_d       = '0;
        cdb_val_d       = '0;
        if (grant_valid) begin
            last_d          = grant_idx;
            cdb_broadcast_d = 1'b1;
            cdb_tag_d       = hold_tag_q[grant_idx];
            cdb_val_d       = hold_val_q[grant_idx];
        end
    end

    // Control state with synchronous reset; held entries are discarded on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid_q    <= '0;
            last_q          <= LAST_RST;
            cdb_broadcast_q <= 1'b0;
            cdb_tag_q       <= '0;
            cdb_val_q       <= '0;
            tag_err_q       <= 1'b0;
        end else begin
            hold_valid_q    <= hold_valid_d;
            last_q          <= last_d;
            cdb_broadcast_q <= cdb_broadcast_d;
            cdb_tag_q       <= cdb_tag_d;
            cdb_val_q       <= cdb_val_d;
            tag_err_q       <= tag_err_d;
        end
    end

    // Hold payloads are qualified by hold_valid_q and need no reset.
    always_ff @(posedge clk) begin
        hold_tag_q <= hold_tag_d;
        hold_val_q <= hold_val_d;
    end

    assign bus.cdb_broadcast = cdb_broadcast_q;
    assign bus.cdb_tag       = cdb_tag_q;
    assign bus.cdb_val       = cdb_val_q;
    assign bus.tag_err       = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner sequences, random run.
module tb_cdb_arbiter;

    localparam int NS = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.N_SRC(NS), .TAG_W(TW), .DATA_W(DW)) bus ();

    cdb_arbiter #(.N_SRC(NS), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] v, input logic [19:0] t,
                         input logic [127:0] d);
        rst          = r;
        bus.fu_valid = v;
        bus.fu_tag   = t;
        bus.fu_val   = d;
    endtask

    // One directed cycle: inputs, ready seen before the edge, outputs after it.
    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [19:0] tags;   // {src3, src2, src1, src0}
        logic [31:0] vals;   // 8-bit values, same order
        logic [3:0]  e_rdy;
        logic        e_bc;
        logic [4:0]  e_tag;
        logic [7:0]  e_val;
        logic        e_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [3:0] v, input logic [19:0] t,
                       input logic [31:0] d, input logic [3:0] er, input logic eb,
                       input logic [4:0] et, input logic [7:0] ev, input logic ee);
        vec_t x;
        x = '{r, v, t, d, er, eb, et, ev, ee};
        vecs.push_back(x);
    endtask

    // Random-phase reference model state.
    bit          m_hv[NS];
    logic [4:0]  m_tag[NS];
    logic [31:0] m_val[NS];
    int          m_last;
    bit          m_err;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] val;
        int          entry;
    } sb_t;

    sb_t sb[$];
    int  cyc = 0;

    logic [3:0]  r_v;
    logic [4:0]  r_tag[NS];
    logic [31:0] r_val[NS];

    initial begin
        logic [127:0] wide;
        logic [3:0]   held;
        logic [3:0]   exp_rdy;
        int           g;
        int           c;
        logic         e_bc;
        logic [4:0]   e_tag;
        logic [31:0]  e_val;
        int           found;
        int           lat;

        drive(1'b1, 4'b0, 20'b0, 128'b0);

        // rst v      tags{3,2,1,0}                vals{3,2,1,0}        rdy     bc tag val err
        add(1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 0);
        add(0, 4'b0010, {5'd0, 5'd0, 5'd5, 5'd0},  {8'd0, 8'd0, 8'd7, 8'd0},   4'b1111, 0, 0, 0, 0);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 1, 5, 7, 0);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 0);
        add(0, 4'b0001, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd9},   4'b1111, 0, 0, 0, 1);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 1);
        add(0, 4'b0100, {5'd0, 5'd6, 5'd0, 5'd0},  {8'd0, 8'd60, 8'd0, 8'd0},  4'b1111, 0, 0, 0, 1);
        add(0, 4'b0100, {5'd0, 5'd7, 5'd0, 5'd0},  {8'd0, 8'd70, 8'd0, 8'd0},  4'b1111, 1, 6, 60, 1);
        add(0, 4'b0100, {5'd0, 5'd8, 5'd0, 5'd0},  {8'd0, 8'd80, 8'd0, 8'd0},  4'b1111, 1, 7, 70, 1);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 1, 8, 80, 1);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 1);
        add(0, 4'b1000, {5'd9, 5'd0, 5'd0, 5'd0},  {8'd90, 8'd0, 8'd0, 8'd0},  4'b1111, 0, 0, 0, 1);
        add(0, 4'b1001, {5'd11, 5'd0, 5'd0, 5'd10}, {8'd110, 8'd0, 8'd0, 8'd100},
            4'b1111, 1, 9, 90, 1);
        add(0, 4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, {8'd120, 8'd0, 8'd0, 8'd0}, 4'b0111, 1, 10, 100, 1);
        add(0, 4'b1000, {5'd12, 5'd0, 5'd0, 5'd0}, {8'd120, 8'd0, 8'd0, 8'd0}, 4'b1111, 1, 11, 110, 1);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 1, 12, 120, 1);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 1);
        add(1, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b0000, 0, 0, 0, 0);
        add(0, 4'b0000, {5'd0, 5'd0, 5'd0, 5'd0},  {8'd0, 8'd0, 8'd0, 8'd0},   4'b1111, 0, 0, 0, 0);

        foreach (vecs[k]) begin
            wide = '0;
            for (int i = 0; i < NS; i++) begin
                wide[i*32 +: 32] = {24'd0, vecs[k].vals[i*8 +: 8]};
            end
            drive(vecs[k].rst, vecs[k].v, vecs[k].tags, wide);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", k), 64'(bus.fu_ready), 64'(vecs[k].e_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_bc", k), 64'(bus.cdb_broadcast), 64'(vecs[k].e_bc));
            chk($sformatf("vec%0d_tag", k), 64'(bus.cdb_tag), 64'(vecs[k].e_tag));
            chk($sformatf("vec%0d_val", k), 64'(bus.cdb_val), 64'(vecs[k].e_val));
            chk($sformatf("vec%0d_err", k), 64'(bus.tag_err), 64'(vecs[k].e_err));
        end

        // All four sources offer at once: broadcasts in tag order, held slots not ready.
        drive(0, 4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, {32'd40, 32'd30, 32'd20, 32'd10});
        @(negedge clk);
        chk("all4_offer_ready", 64'(bus.fu_ready), 64'(4'b1111));
        @(posedge clk);
        #1;
        chk("all4_offer_bc", 64'(bus.cdb_broadcast), 64'd0);
        drive(0, 4'b0000, 20'b0, 128'b0);
        for (int k = 0; k < NS; k++) begin
            held    = 4'b1111 << k;
            exp_rdy = ~held | (4'b0001 << k);
            @(negedge clk);
            chk($sformatf("all4_ready%0d", k), 64'(bus.fu_ready), 64'(exp_rdy));
            @(posedge clk);
            #1;
            chk($sformatf("all4_bc%0d", k), 64'(bus.cdb_broadcast), 64'd1);
            chk($sformatf("all4_tag%0d", k), 64'(bus.cdb_tag), 64'(k + 1));
            chk($sformatf("all4_val%0d", k), 64'(bus.cdb_val), 64'((k + 1) * 10));
        end
        @(negedge clk);
        chk("all4_idle_ready", 64'(bus.fu_ready), 64'(4'b1111));
        @(posedge clk);
        #1;
        chk("all4_idle_bc", 64'(bus.cdb_broadcast), 64'd0);

        // Reset while all four slots are full: nothing held may leak out afterwards.
        drive(0, 4'b1111, {5'd24, 5'd23, 5'd22, 5'd21}, {32'd4, 32'd3, 32'd2, 32'd1});
        @(posedge clk);
        #1;
        drive(1, 4'b0000, 20'b0, 128'b0);
        @(negedge clk);
        chk("rstmid_ready", 64'(bus.fu_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("rstmid_bc", 64'(bus.cdb_broadcast), 64'd0);
        chk("rstmid_tag", 64'(bus.cdb_tag), 64'd0);
        drive(0, 4'b0000, 20'b0, 128'b0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("rstpost_ready%0d", k), 64'(bus.fu_ready), 64'(4'b1111));
            @(posedge clk);
            #1;
            chk($sformatf("rstpost_bc%0d", k), 64'(bus.cdb_broadcast), 64'd0);
        end

        // Random offers against the reference model, then a drain period.
        for (int i = 0; i < NS; i++) m_hv[i] = 0;
        m_last = NS - 1;
        m_err  = 0;
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NS; i++) begin
                r_v[i]   = (n < 390) && ($urandom_range(0, 3) != 0);
                r_tag[i] = 5'($urandom_range(0, 31));
                r_val[i] = $urandom;
                bus.fu_tag[i*TW +: TW] = r_tag[i];
                bus.fu_val[i*DW +: DW] = r_val[i];
            end
            bus.fu_valid = r_v;

            g = -1;
            for (int off = 1; off <= NS; off++) begin
                c = (m_last + off) % NS;
                if (g < 0 && m_hv[c]) g = c;
            end
            for (int i = 0; i < NS; i++) exp_rdy[i] = !m_hv[i] || (g == i);
            e_bc  = (g >= 0);
            e_tag = (g >= 0) ? m_tag[g] : 5'd0;
            e_val = (g >= 0) ? m_val[g] : 32'd0;

            @(negedge clk);
            chk($sformatf("rnd%0d_ready", n), 64'(bus.fu_ready), 64'(exp_rdy));

            if (g >= 0) begin
                m_hv[g] = 0;
                m_last  = g;
            end
            for (int i = 0; i < NS; i++) begin
                if (r_v[i] && exp_rdy[i]) begin
                    if (r_tag[i] == 5'd0) begin
                        m_err = 1;
                    end else begin
                        m_hv[i]  = 1;
                        m_tag[i] = r_tag[i];
                        m_val[i] = r_val[i];
                        sb.push_back('{r_tag[i], r_val[i], cyc + 1});
                    end
                end
            end

            @(posedge clk);
            #1;
            cyc++;
            chk($sformatf("rnd%0d_bc", n), 64'(bus.cdb_broadcast), 64'(e_bc));
            chk($sformatf("rnd%0d_tag", n), 64'(bus.cdb_tag), 64'(e_tag));
            chk($sformatf("rnd%0d_val", n), 64'(bus.cdb_val), 64'(e_val));
            chk($sformatf("rnd%0d_err", n), 64'(bus.tag_err), 64'(m_err));

            if (bus.cdb_broadcast === 1'b1) begin
                found = -1;
                foreach (sb[j]) begin
                    if (found < 0 && sb[j].tag == bus.cdb_tag && sb[j].val == bus.cdb_val)
                        found = j;
                end
                chk($sformatf("rnd%0d_sb_known", n), 64'(found >= 0), 64'd1);
                if (found >= 0) begin
                    lat = cyc - sb[found].entry;
                    chk($sformatf("rnd%0d_sb_latency", n), 64'(lat <= NS && lat >= 1), 64'd1);
                    sb.delete(found);
                end
            end
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
